// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory responder and its RAM array.
// Build option: define MEM_PARITY_EN to add per-lane odd parity storage and checking.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ODD  = 2'b01;
    localparam logic [1:0] ERR_NXM  = 2'b10;
    localparam logic [1:0] ERR_PAR  = 2'b11;

    // Odd parity: data plus parity bit always holds an odd number of ones.
    function automatic logic byte_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Two 8-bit lane RAMs with per-lane write enables and a registered read port.
// Build option: MEM_PARITY_EN adds one stored parity bit per lane word.
module mem_array #(
    parameter int MEM_WORDS = 4096,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic               clk,
    input  logic [AW-1:0]      i_addr,
    input  logic               i_re,
    input  logic [1:0]         i_we,
    input  logic [1:0][7:0]    i_wdata,
`ifdef MEM_PARITY_EN
    input  logic [1:0]         i_wpar,
    output logic [1:0]         o_rpar,
`endif
    output logic [1:0][7:0]    o_rdata
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] r_ram [0:MEM_WORDS-1];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (i_we[gi]) begin
                r_ram[i_addr] <= i_wdata[gi];
            end
            if (i_re) begin
                r_q <= r_ram[i_addr];
            end
        end

        assign o_rdata[gi] = r_q;

`ifdef MEM_PARITY_EN
        logic r_par_ram [0:MEM_WORDS-1];
        logic r_par_q;

        always_ff @(posedge clk) begin
            if (i_we[gi]) begin
                r_par_ram[i_addr] <= i_wpar[gi];
            end
            if (i_re) begin
                r_par_q <= r_par_ram[i_addr];
            end
        end

        assign o_rpar[gi] = r_par_q;
`endif
    end

endmodule

// File: rtl/mem_responder.sv
// Req/ack memory responder: FSM, wait-state counter, request latch, error decode, output muxing.
// Build option: MEM_PARITY_EN enables parity checking and the par_inject test port.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic        bytew,
    input  logic [15:0] addr,
    input  logic [15:0] d_in,
`ifdef MEM_PARITY_EN
    input  logic        par_inject,
`endif
    output logic        ack,
    output logic [15:0] d_out,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int          AW         = $clog2(MEM_WORDS);
    localparam logic [16:0] BYTE_LIMIT = 17'(2 * MEM_WORDS);
    localparam logic [3:0]  CNT_LAST   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_bytew;
    logic [15:0] r_addr;
    logic [15:0] r_d_in;
    logic        r_ack;
    logic [1:0]  r_code;
    logic        r_rd;
    logic        r_ack_byte;
    logic        r_ack_hi;

    logic            w_we;
    logic            w_bytew;
    logic [15:0]     w_addr;
    logic [15:0]     w_d_in;
    logic            w_commit;
    logic [1:0]      w_code;
    logic            w_wr_ok;
    logic [1:0]      w_lane_we;
    logic [1:0][7:0] w_wdata;
    logic [1:0][7:0] w_rdata;
    logic [15:0]     w_rd_val;
    logic            w_par_bad;

    // With zero wait states the commit edge is the sampling edge, so use live inputs in IDLE.
    always_comb begin
        w_we    = (r_state == IDLE) ? we    : r_we;
        w_bytew = (r_state == IDLE) ? bytew : r_bytew;
        w_addr  = (r_state == IDLE) ? addr  : r_addr;
        w_d_in  = (r_state == IDLE) ? d_in  : r_d_in;
    end

    always_comb begin
        w_commit = req && (((r_state == IDLE) && (WAIT_STATES == 0)) ||
                           ((r_state == WAIT) && (r_cnt == CNT_LAST)));
        if (!w_bytew && w_addr[0]) begin
            w_code = ERR_ODD;
        end else if ({1'b0, w_addr} >= BYTE_LIMIT) begin
            w_code = ERR_NXM;
        end else begin
            w_code = ERR_NONE;
        end
        w_wr_ok      = w_commit && w_we && (w_code == ERR_NONE);
        w_lane_we[0] = w_wr_ok && (!w_bytew || !w_addr[0]);
        w_lane_we[1] = w_wr_ok && (!w_bytew || w_addr[0]);
        w_wdata[0]   = w_d_in[7:0];
        w_wdata[1]   = w_bytew ? w_d_in[7:0] : w_d_in[15:8];
    end

`ifdef MEM_PARITY_EN
    logic [1:0] w_wpar;
    logic [1:0] w_rpar;

    assign w_wpar[0] = byte_parity(w_wdata[0]) ^ par_inject;
    assign w_wpar[1] = byte_parity(w_wdata[1]) ^ par_inject;
    assign w_par_bad = r_rd &&
        (((!r_ack_byte || !r_ack_hi) && (w_rpar[0] != byte_parity(w_rdata[0]))) ||
         ((!r_ack_byte ||  r_ack_hi) && (w_rpar[1] != byte_parity(w_rdata[1]))));
`else
    assign w_par_bad = 1'b0;
`endif

    mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_mem_array (
        .clk     (clk),
        .i_addr  (w_addr[AW:1]),
        .i_re    (w_commit && !w_we && (w_code == ERR_NONE)),
        .i_we    (w_lane_we),
        .i_wdata (w_wdata),
`ifdef MEM_PARITY_EN
        .i_wpar  (w_wpar),
        .o_rpar  (w_rpar),
`endif
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_bytew    <= 1'b0;
            r_addr     <= 16'h0000;
            r_d_in     <= 16'h0000;
            r_ack      <= 1'b0;
            r_code     <= ERR_NONE;
            r_rd       <= 1'b0;
            r_ack_byte <= 1'b0;
            r_ack_hi   <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_code <= ERR_NONE;
            r_rd   <= 1'b0;
            if (w_commit) begin
                r_ack      <= 1'b1;
                r_code     <= w_code;
                r_rd       <= !w_we && (w_code == ERR_NONE);
                r_ack_byte <= w_bytew;
                r_ack_hi   <= w_addr[0];
            end
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_bytew <= bytew;
                        r_addr  <= addr;
                        r_d_in  <= d_in;
                        r_cnt   <= 4'd0;
                        r_state <= (WAIT_STATES == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        r_state <= IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_val = r_ack_byte ? {8'h00, (r_ack_hi ? w_rdata[1] : w_rdata[0])}
                              : {w_rdata[1], w_rdata[0]};
        ack      = r_ack;
        d_out    = (r_ack && r_rd) ? w_rd_val : 16'h0000;
        err      = r_ack && ((r_code != ERR_NONE) || w_par_bad);
        if (!r_ack) begin
            err_code = ERR_NONE;
        end else if (r_code != ERR_NONE) begin
            err_code = r_code;
        end else if (w_par_bad) begin
            err_code = ERR_PAR;
        end else begin
            err_code = ERR_NONE;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: directed steps plus random traffic against a word-array reference model.
// Two responders run side by side: one with 1 wait state, one with 3 wait states.
module tb_mem_responder;

    localparam int MW = 4096;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        req, we, bytew, par_inject;
    logic [1:0][15:0]  addr, d_in;
    logic [1:0]        ack_o, err_o;
    logic [1:0][15:0]  dout_o;
    logic [1:0][1:0]   code_o;

    int checks = 0;
    int errors = 0;
    logic [15:0] model [int];

    always #5 clk = ~clk;

    mem_responder #(.MEM_WORDS(MW), .WAIT_STATES(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .req(req[0]), .we(we[0]), .bytew(bytew[0]),
        .addr(addr[0]), .d_in(d_in[0]),
`ifdef MEM_PARITY_EN
        .par_inject(par_inject[0]),
`endif
        .ack(ack_o[0]), .d_out(dout_o[0]), .err(err_o[0]), .err_code(code_o[0])
    );

    mem_responder #(.MEM_WORDS(MW), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req[1]), .we(we[1]), .bytew(bytew[1]),
        .addr(addr[1]), .d_in(d_in[1]),
`ifdef MEM_PARITY_EN
        .par_inject(par_inject[1]),
`endif
        .ack(ack_o[1]), .d_out(dout_o[1]), .err(err_o[1]), .err_code(code_o[1])
    );

    function automatic int ws(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: error priority, byte lanes and little-endian words from plain arithmetic.
    task automatic predict(input int s, input logic w, input logic b, input logic [15:0] a,
                           input logic [15:0] d, output logic [1:0] ec, output logic [15:0] ed);
        int key = (s << 16) + int'(a / 2);
        logic [15:0] cur;
        ec = 2'd0;
        ed = 16'h0000;
        if (!b && (a % 2 == 1)) ec = 2'd1;
        else if (int'(a) >= 2 * MW) ec = 2'd2;
        if (ec != 2'd0) return;
        cur = model.exists(key) ? model[key] : 16'h0000;
        if (!w) begin
            if (!b) ed = cur;
            else if (a % 2 == 1) ed = cur / 256;
            else ed = cur % 256;
        end else begin
            if (!b) model[key] = d;
            else if (a % 2 == 1) model[key] = 16'((d % 256) * 256 + (cur % 256));
            else model[key] = 16'((cur / 256) * 256 + (d % 256));
        end
    endtask

    task automatic access(input int s, input logic w, input logic b, input logic [15:0] a,
                          input logic [15:0] d, input logic inj, output int lat,
                          output logic [15:0] dout, output logic e, output logic [1:0] code);
        lat  = -1;
        dout = 16'h0000;
        e    = 1'b0;
        code = 2'd0;
        @(negedge clk);
        req[s] = 1'b1; we[s] = w; bytew[s] = b; addr[s] = a; d_in[s] = d; par_inject[s] = inj;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ack_o[s]) begin
                lat  = c;
                dout = dout_o[s];
                e    = err_o[s];
                code = code_o[s];
                break;
            end
        end
        req[s] = 1'b0;
        par_inject[s] = 1'b0;
    endtask

    task automatic xact(input int s, input logic w, input logic b, input logic [15:0] a,
                        input logic [15:0] d, input logic inj, input string tag);
        int lat;
        logic [15:0] dout, ed;
        logic e;
        logic [1:0] c, ec;
        predict(s, w, b, a, d, ec, ed);
        access(s, w, b, a, d, inj, lat, dout, e, c);
        $display("%s: dut%0d we=%0b byte=%0b addr=%h din=%h -> lat=%0d dout=%h err=%0b code=%0d",
                 tag, s, w, b, a, d, lat, dout, e, c);
        chk({tag, ".latency"}, lat, ws(s) + 1);
        chk({tag, ".err"}, e, (ec != 2'd0));
        chk({tag, ".code"}, c, ec);
        if (!w) chk({tag, ".dout"}, dout, ed);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [15:0] dout;
        logic e, seen;
        logic [1:0] c;
        logic [15:0] pool [8];

        req = '0; we = '0; bytew = '0; par_inject = '0; addr = '0; d_in = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset.ack%0d", s), ack_o[s], 1'b0);
            chk($sformatf("reset.err%0d", s), err_o[s], 1'b0);
            chk($sformatf("reset.code%0d", s), code_o[s], 2'd0);
            chk($sformatf("reset.dout%0d", s), dout_o[s], 16'h0000);
        end
        reset_n = 1'b1;

        // Word write/read round trip
        xact(0, 1'b1, 1'b0, 16'o001000, 16'o123456, 1'b0, "t1.wr");
        xact(0, 1'b0, 1'b0, 16'o001000, 16'h0000, 1'b0, "t1.rd");
        chk("t1.value", model[16'o001000 / 2], 16'o123456);
        @(negedge clk);
        chk("t1.ack_pulse", ack_o[0], 1'b0);
        chk("t1.idle_dout", dout_o[0], 16'h0000);

        // Byte lane merge
        xact(0, 1'b1, 1'b0, 16'h1000, 16'h1234, 1'b0, "t2.wr");
        xact(0, 1'b1, 1'b1, 16'h1001, 16'h00AB, 1'b0, "t2.bwr");
        xact(0, 1'b0, 1'b0, 16'h1000, 16'h0000, 1'b0, "t2.rd");
        xact(0, 1'b0, 1'b1, 16'h1001, 16'h0000, 1'b0, "t2.brd_hi");
        xact(0, 1'b0, 1'b1, 16'h1000, 16'h0000, 1'b0, "t2.brd_lo");
        chk("t2.value", model[16'h1000 / 2], 16'hAB34);

        // Odd word address
        xact(0, 1'b1, 1'b0, 16'h0002, 16'h7777, 1'b0, "t3.init");
        xact(0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, "t3.rd_odd");
        xact(0, 1'b1, 1'b0, 16'h0003, 16'h9999, 1'b0, "t3.wr_odd");
        xact(0, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, "t3.unchanged");

        // Range boundary; 0x2001 aliases word 0 if the range check leaks
        xact(0, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 1'b0, "t4.init");
        xact(0, 1'b0, 1'b0, 16'h2000, 16'h0000, 1'b0, "t4.rd_nxm");
        xact(0, 1'b1, 1'b1, 16'h2001, 16'h0055, 1'b0, "t4.bwr_nxm");
        xact(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, "t4.unchanged");
        xact(0, 1'b1, 1'b0, 16'h1FFE, 16'hC3A5, 1'b0, "t4.wr_top");
        xact(0, 1'b0, 1'b1, 16'h1FFF, 16'h0000, 1'b0, "t4.brd_top");

        // Random traffic over a small pool of initialised words
        for (int k = 0; k < 8; k++) begin
            pool[k] = 16'($urandom_range(0, MW - 1) * 2);
            xact(0, 1'b1, 1'b0, pool[k], 16'($urandom), 1'b0, $sformatf("rnd.init%0d", k));
        end
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            a = pool[$urandom_range(0, 7)] + 16'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) a = 16'(2 * MW + $urandom_range(0, 16'hFFFF - 2 * MW));
            xact(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom),
                 1'b0, $sformatf("rnd%0d", n));
        end

        // Abort on the 3-wait-state responder: req drops in the 2nd WAIT cycle
        xact(1, 1'b1, 1'b0, 16'h0100, 16'h1111, 1'b0, "t5.init");
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; bytew[1] = 1'b0; addr[1] = 16'h0100; d_in[1] = 16'h2222;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | ack_o[1];
        end
        req[1] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | ack_o[1];
        end
        $display("t5.abort: dut1 addr=0100 din=2222 ack_seen=%0b", seen);
        chk("t5.abort_ack", seen, 1'b0);
        xact(1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, "t5.after_abort");

        // Reset pulse mid-request loses the pending write
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; bytew[1] = 1'b0; addr[1] = 16'h0100; d_in[1] = 16'h3333;
        @(negedge clk);
        reset_n = 1'b0;
        req[1] = 1'b0;
        #1;
        chk("t5.rst_ack", ack_o[1], 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | ack_o[1];
        end
        $display("t5.reset: dut1 addr=0100 din=3333 ack_seen=%0b", seen);
        chk("t5.rst_no_ack", seen, 1'b0);
        xact(1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, "t5.after_reset");
        chk("t5.value", model[(1 << 16) + 16'h0100 / 2], 16'h1111);

`ifdef MEM_PARITY_EN
        // Corrupted parity is reported on read with raw data still returned
        xact(0, 1'b1, 1'b0, 16'h0040, 16'h5555, 1'b1, "t6.wr_inj");
        access(0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, lat, dout, e, c);
        $display("t6.rd_inj: dut0 addr=0040 -> lat=%0d dout=%h err=%0b code=%0d", lat, dout, e, c);
        chk("t6.par_err", e, 1'b1);
        chk("t6.par_code", c, 2'd3);
        chk("t6.par_dout", dout, 16'h5555);
        xact(0, 1'b1, 1'b0, 16'h0040, 16'h5555, 1'b0, "t6.wr_clean");
        xact(0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, "t6.rd_clean");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
